// File: rtl/instr_sequencer_pkg.sv
// seq_pkg: shared constants, opcodes and state type for the program sequencer
package seq_pkg;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int OP_W    = 4;
    localparam int DATA_W  = 8;
    localparam int WORD_W  = OP_W + DATA_W;
    localparam int OP_LSB  = DATA_W;
    localparam int OP_MSB  = WORD_W - 1;
    localparam int IMM_MSB = DATA_W - 1;
    localparam logic [OP_W-1:0] HALT_OP = 4'hF;
    localparam logic [OP_W-1:0] IDLE_OP = 4'hA;
    typedef enum logic [OP_W-1:0] {
        CLR_ALL    = 4'd0,
        MOV_R1     = 4'd1,
        MOV_R2     = 4'd2,
        MOV_OUT_R2 = 4'd3,
        ADD        = 4'd4,
        LSL        = 4'd5,
        LSR        = 4'd6,
        AND        = 4'd7,
        ORR        = 4'd8,
        CMP        = 4'd9
    } opcode_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [WORD_W-1:0] HALT_WORD = {HALT_OP, {DATA_W{1'b0}}};
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: load/control inputs and issue outputs of the sequencer
interface instr_sequencer_if;
    import seq_pkg::*;
    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [WORD_W-1:0]   load_word;
    logic                start;
    logic                step_mode;
    logic                step;
    logic                halt_req;
    logic [OP_W-1:0]     instr_out;
    logic [DATA_W-1:0]   imm_out;
    logic                instr_valid;
    logic [ADDR_W-1:0]   pc;
    logic                busy;
    logic                done;
    modport master (
        output load_en, load_addr, load_word, start, step_mode, step, halt_req,
        input  instr_out, imm_out, instr_valid, pc, busy, done
    );
    modport slave (
        input  load_en, load_addr, load_word, start, step_mode, step, halt_req,
        output instr_out, imm_out, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: program word array, synchronous write, asynchronous read, resets to HALT
module prog_mem
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    // reset fills every word with HALT so an unloaded program stops at once
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= HALT_WORD;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues program words to the decoder in free-run or single-step mode
module instr_sequencer
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.slave   bus
);
    state_e              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [OP_W-1:0]     r_instr, w_instr_nxt;
    logic [DATA_W-1:0]   r_imm, w_imm_nxt;
    logic                r_valid;
    logic [WORD_W-1:0]   w_word;
    logic [OP_W-1:0]     w_op;
    logic                w_adv, w_issue, w_end;

    prog_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (bus.load_en && r_state != RUN),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_word),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_op    = w_word[OP_MSB:OP_LSB];
    assign w_adv   = !bus.step_mode || bus.step;
    assign w_issue = r_state == RUN && !bus.halt_req && w_adv && w_op != HALT_OP;
    assign w_end   = bus.halt_req || (w_adv && (w_op == HALT_OP || r_pc == ADDR_W'(DEPTH - 1)));

    // state, pc and issue registers; outputs are registered toward the decoder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_instr <= IDLE_OP;
            r_imm   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_imm   <= w_imm_nxt;
            r_valid <= w_issue;
        end
    end

    // next state: start leaves IDLE/DONE, halt/HALT word/last address end RUN
    always_comb begin
        w_next = r_state;
        if (r_state != RUN) w_next = bus.start ? RUN : r_state;
        else                w_next = w_end ? DONE : RUN;
    end

    // next issue values: idle opcode and zero immediate whenever nothing is issued
    always_comb begin
        w_instr_nxt = w_issue ? w_op : IDLE_OP;
        w_imm_nxt   = w_issue ? w_word[IMM_MSB:0] : '0;
        w_pc_nxt    = (r_state != RUN && bus.start) ? '0 : (w_issue ? r_pc + 1'b1 : r_pc);
    end

    assign bus.instr_out   = r_instr;
    assign bus.imm_out     = r_imm;
    assign bus.instr_valid = r_valid;
    assign bus.pc          = r_pc;
    assign bus.busy        = r_state == RUN;
    assign bus.done        = r_state == DONE;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for the program sequencer
module tb_instr_sequencer;
    import seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    logic [WORD_W-1:0] exp_q[$];

    instr_sequencer_if bus();
    instr_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // monitor: every issued word must match the scoreboard head; idle cycles show IDLE_OP/0
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.instr_valid === 1'b1) begin
                valid_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue got=%h_%h want=none", bus.instr_out, bus.imm_out);
                end else begin
                    logic [WORD_W-1:0] w;
                    w = exp_q.pop_front();
                    if ({bus.instr_out, bus.imm_out} !== w) begin
                        bad++;
                        $display("FAIL issue_word got=%h_%h want=%h", bus.instr_out, bus.imm_out, w);
                    end
                end
            end else begin
                total++;
                if (bus.instr_out !== IDLE_OP || bus.imm_out !== 8'h00 || bus.instr_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_output got=%h_%h v=%b want=a_00 v=0", bus.instr_out, bus.imm_out, bus.instr_valid);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.load_en = 0; bus.load_addr = '0; bus.load_word = '0;
        bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.halt_req = 0;
        rst = 1;
        cyc(2);
        rst = 0;
        mon_en = 1;
    endtask

    task automatic load(input int addr, input logic [WORD_W-1:0] word);
        bus.load_en = 1; bus.load_addr = ADDR_W'(addr); bus.load_word = word;
        cyc(1);
        bus.load_en = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1;
        cyc(1);
        bus.start = 0;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < maxc) begin
            cyc(1);
            n++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=%b want=1 after %0d cycles", bus.done, n);
        end
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        total++;
        if ({bus.instr_valid, bus.instr_out, bus.imm_out, bus.pc, bus.busy, bus.done} !== {1'b0, 4'hA, 8'h00, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got=v%b op%h imm%h pc%h b%b d%b want=v0 opa imm00 pc0 b0 d0",
                     bus.instr_valid, bus.instr_out, bus.imm_out, bus.pc, bus.busy, bus.done);
        end
        base = valid_cnt;
        pulse_start();
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL empty_busy got=%b want=1", bus.busy); end
        cyc(1);
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b want=1", bus.done); end
        cyc(1);
        total++;
        if (valid_cnt != base) begin bad++; $display("FAIL empty_issues got=%0d want=0", valid_cnt - base); end
    endtask

    task automatic test_free_run();
        int base, n;
        load(0, 12'h105); load(1, 12'h203); load(2, 12'h400); load(3, 12'hF00);
        exp_q.push_back(12'h105); exp_q.push_back(12'h203); exp_q.push_back(12'h400);
        base = valid_cnt;
        pulse_start();
        cyc(1);
        total++;
        if (bus.instr_valid !== 1'b1 || bus.instr_out !== 4'h1) begin
            bad++;
            $display("FAIL first_latency got=v%b op%h want=v1 op1", bus.instr_valid, bus.instr_out);
        end
        wait_done(10, n);
        total++;
        if (n != 3) begin bad++; $display("FAIL free_run_cycles got=%0d want=3", n); end
        total++;
        if (bus.pc !== 4'd3) begin bad++; $display("FAIL free_run_pc got=%0d want=3", bus.pc); end
        cyc(1);
        total++;
        if (valid_cnt - base != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL free_run_count got=%0d left=%0d want=3 left=0", valid_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_step();
        int issued, base;
        logic s;
        issued = 0;
        base = valid_cnt;
        exp_q.push_back(12'h105); exp_q.push_back(12'h203); exp_q.push_back(12'h400);
        bus.step_mode = 1;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            s = (k % 3 == 2);
            bus.step = s;
            cyc(1);
            bus.step = 0;
            if (s && issued < 3) begin
                total++;
                if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL step_issue k=%0d got=%b want=1", k, bus.instr_valid); end
                issued++;
            end else if (!s) begin
                total++;
                if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL step_hold k=%0d got=%b want=0", k, bus.instr_valid); end
            end
            total++;
            if (bus.pc !== ADDR_W'(issued)) begin bad++; $display("FAIL step_pc k=%0d got=%0d want=%0d", k, bus.pc, issued); end
        end
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL step_done got=%b want=1", bus.done); end
        bus.step_mode = 0;
        cyc(1);
        total++;
        if (valid_cnt - base != 3) begin bad++; $display("FAIL step_count got=%0d want=3", valid_cnt - base); end
    endtask

    task automatic test_full();
        int base, n;
        for (int i = 0; i < DEPTH; i++) load(i, {4'h7, 8'(i)});
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({4'h7, 8'(i)});
        base = valid_cnt;
        pulse_start();
        wait_done(40, n);
        cyc(1);
        total++;
        if (bus.pc !== 4'd0 || bus.done !== 1'b1) begin bad++; $display("FAIL full_end got=pc%0d d%b want=pc0 d1", bus.pc, bus.done); end
        total++;
        if (valid_cnt - base != DEPTH || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_count got=%0d left=%0d want=16 left=0", valid_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_halt();
        int base, n;
        base = valid_cnt;
        exp_q.push_back(12'h700);
        pulse_start();
        cyc(1);
        bus.halt_req = 1;
        cyc(1);
        bus.halt_req = 0;
        total++;
        if (bus.done !== 1'b1 || bus.pc !== 4'd1 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_req got=d%b pc%0d v%b want=d1 pc1 v0", bus.done, bus.pc, bus.instr_valid);
        end
        bus.halt_req = 1;
        cyc(2);
        bus.halt_req = 0;
        total++;
        if (bus.done !== 1'b1 || bus.pc !== 4'd1) begin bad++; $display("FAIL halt_idle got=d%b pc%0d want=d1 pc1", bus.done, bus.pc); end
        total++;
        if (valid_cnt - base != 1) begin bad++; $display("FAIL halt_count got=%0d want=1", valid_cnt - base); end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({4'h7, 8'(i)});
        pulse_start();
        total++;
        if (bus.pc !== 4'd0 || bus.busy !== 1'b1) begin bad++; $display("FAIL rerun_start got=pc%0d b%b want=pc0 b1", bus.pc, bus.busy); end
        wait_done(40, n);
        cyc(1);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rerun_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int base, n;
        exp_q.push_back(12'h700); exp_q.push_back(12'h701);
        pulse_start();
        cyc(2);
        rst = 1;
        cyc(1);
        rst = 0;
        total++;
        if ({bus.instr_valid, bus.instr_out, bus.pc, bus.busy, bus.done} !== {1'b0, 4'hA, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got=v%b op%h pc%0d b%b d%b want=v0 opa pc0 b0 d0",
                     bus.instr_valid, bus.instr_out, bus.pc, bus.busy, bus.done);
        end
        base = valid_cnt;
        pulse_start();
        cyc(1);
        total++;
        if (bus.done !== 1'b1 || valid_cnt != base) begin
            bad++;
            $display("FAIL after_reset_halt got=d%b n%0d want=d1 n0", bus.done, valid_cnt - base);
        end
        load(0, 12'h111);
        exp_q.push_back(12'h111);
        pulse_start();
        bus.load_en = 1; bus.load_addr = 4'd1; bus.load_word = 12'h222;
        cyc(1);
        bus.load_en = 0;
        wait_done(10, n);
        exp_q.push_back(12'h111);
        pulse_start();
        wait_done(10, n);
        cyc(1);
        total++;
        if (valid_cnt - base != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL run_load_ignored got=%0d left=%0d want=2 left=0", valid_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_load_with_start();
        int n;
        exp_q.push_back(12'h333);
        bus.load_en = 1; bus.load_addr = 4'd0; bus.load_word = 12'h333;
        pulse_start();
        bus.load_en = 0;
        wait_done(10, n);
        cyc(1);
        total++;
        if (exp_q.size() != 0 || bus.pc !== 4'd1) begin
            bad++;
            $display("FAIL load_with_start got=left%0d pc%0d want=left0 pc1", exp_q.size(), bus.pc);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_full();
        test_halt();
        test_reset_mid();
        test_load_with_start();
        cyc(2);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL leftover got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
